// File: rtl/pong_pkg.sv
// Shared encodings for the pong game controller: ball directions, FSM states
// and default display geometry.
package pong_pkg;

  localparam logic [1:0] UP_LEFT    = 2'b00;
  localparam logic [1:0] DOWN_LEFT  = 2'b01;
  localparam logic [1:0] UP_RIGHT   = 2'b10;
  localparam logic [1:0] DOWN_RIGHT = 2'b11;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SERVE = 3'd1;
  localparam logic [2:0] PLAY  = 3'd2;
  localparam logic [2:0] POINT = 3'd3;
  localparam logic [2:0] OVER  = 3'd4;

  localparam int DEF_DISP_COLS = 800;
  localparam int DEF_DISP_ROWS = 600;

  // The next serve heads toward whoever just conceded the point.
  function automatic logic [1:0] serve_toward(input logic left_conceded);
    return left_conceded ? UP_LEFT : UP_RIGHT;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running divider producing a one-cycle enable every DIV clocks; the ball
// mover runs on this enable instead of a derived slow clock.
module tick_gen #(
  parameter int DIV = 100000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (count_reg == LAST) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign tick = (count_reg == LAST);

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: serves the ball, detects goal-line misses, keeps the
// scores and declares a winner. Drives the ball mover through move_tick/ball_load.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int DISP_COLS   = DEF_DISP_COLS,
  parameter int DISP_ROWS   = DEF_DISP_ROWS,
  parameter int TICK_DIV    = 100000,
  parameter int SERVE_DELAY = 120,
  parameter int WIN_SCORE   = 7,
  parameter int L_GOAL_COL  = 4,
  parameter int R_GOAL_COL  = DISP_COLS - 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        pause,
  input  logic [11:0] ball_center_col,
  output logic        move_tick,
  output logic        ball_load,
  output logic [11:0] load_col,
  output logic [11:0] load_row,
  output logic [1:0]  serve_dir,
  output logic [3:0]  score_l,
  output logic [3:0]  score_r,
  output logic        game_over,
  output logic        winner,
  output logic [2:0]  state_o
);

  localparam int SCW = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
  localparam logic [SCW-1:0] SERVE_LAST = SCW'(SERVE_DELAY - 1);
  localparam logic [3:0]     WIN        = 4'(WIN_SCORE);

  logic           tick;
  logic           start_q_reg;
  logic           start_rise;
  logic [2:0]     state_reg;
  logic [SCW-1:0] serve_cnt_reg;
  logic [3:0]     score_l_reg;
  logic [3:0]     score_r_reg;
  logic           scorer_r_reg;
  logic [1:0]     serve_dir_reg;
  logic           move_tick_reg;
  logic           ball_load_reg;
  logic           game_over_reg;
  logic           winner_reg;
  logic [3:0]     scorer_score;

  tick_gen #(
    .DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // Tracks the button even through reset so a held start never counts as an edge.
  always_ff @(posedge clk) begin
    start_q_reg <= start;
  end

  assign start_rise   = start & ~start_q_reg;
  assign scorer_score = scorer_r_reg ? score_r_reg : score_l_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      serve_cnt_reg <= '0;
      score_l_reg   <= '0;
      score_r_reg   <= '0;
      scorer_r_reg  <= 1'b0;
      serve_dir_reg <= UP_RIGHT;
      move_tick_reg <= 1'b0;
      ball_load_reg <= 1'b0;
      game_over_reg <= 1'b0;
      winner_reg    <= 1'b0;
    end else begin
      ball_load_reg <= 1'b0;
      move_tick_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start_rise) begin
            score_l_reg   <= '0;
            score_r_reg   <= '0;
            serve_cnt_reg <= '0;
            ball_load_reg <= 1'b1;
            state_reg     <= SERVE;
          end
        end
        SERVE: begin
          if (tick && !pause) begin
            if (serve_cnt_reg == SERVE_LAST) begin
              state_reg <= PLAY;
            end else begin
              serve_cnt_reg <= serve_cnt_reg + 1'b1;
            end
          end
        end
        PLAY: begin
          move_tick_reg <= tick & ~pause;
          // Score is committed on entry to POINT so it is visible during POINT.
          if (ball_center_col <= 12'(L_GOAL_COL)) begin
            if (score_r_reg != WIN) score_r_reg <= score_r_reg + 1'b1;
            scorer_r_reg  <= 1'b1;
            serve_dir_reg <= serve_toward(1'b1);
            state_reg     <= POINT;
          end else if (ball_center_col >= 12'(R_GOAL_COL)) begin
            if (score_l_reg != WIN) score_l_reg <= score_l_reg + 1'b1;
            scorer_r_reg  <= 1'b0;
            serve_dir_reg <= serve_toward(1'b0);
            state_reg     <= POINT;
          end
        end
        POINT: begin
          if (scorer_score == WIN) begin
            game_over_reg <= 1'b1;
            winner_reg    <= scorer_r_reg;
            state_reg     <= OVER;
          end else begin
            serve_cnt_reg <= '0;
            ball_load_reg <= 1'b1;
            state_reg     <= SERVE;
          end
        end
        OVER: begin
          if (start_rise) begin
            score_l_reg   <= '0;
            score_r_reg   <= '0;
            game_over_reg <= 1'b0;
            serve_dir_reg <= UP_RIGHT;
            serve_cnt_reg <= '0;
            ball_load_reg <= 1'b1;
            state_reg     <= SERVE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign move_tick = move_tick_reg;
  assign ball_load = ball_load_reg;
  assign load_col  = 12'(DISP_COLS / 2);
  assign load_row  = 12'(DISP_ROWS / 2);
  assign serve_dir = serve_dir_reg;
  assign score_l   = score_l_reg;
  assign score_r   = score_r_reg;
  assign game_over = game_over_reg;
  assign winner    = winner_reg;
  assign state_o   = state_reg;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: directed scenarios plus random play, every cycle
// checked against a cycle-level game model.
module tb_pong_game_ctrl;
  import pong_pkg::*;

  localparam int TD   = 4;
  localparam int SD   = 3;
  localparam int WS   = 4;
  localparam int COLS = 800;
  localparam int ROWS = 600;
  localparam int LG   = 4;
  localparam int RG   = COLS - 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic [11:0] ball_center_col = 12'd400;
  logic        move_tick, ball_load, game_over, winner;
  logic [11:0] load_col, load_row;
  logic [1:0]  serve_dir;
  logic [3:0]  score_l, score_r;
  logic [2:0]  state_o;

  int errors = 0;
  int checks = 0;

  pong_game_ctrl #(
    .DISP_COLS   (COLS),
    .DISP_ROWS   (ROWS),
    .TICK_DIV    (TD),
    .SERVE_DELAY (SD),
    .WIN_SCORE   (WS),
    .L_GOAL_COL  (LG),
    .R_GOAL_COL  (RG)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .pause           (pause),
    .ball_center_col (ball_center_col),
    .move_tick       (move_tick),
    .ball_load       (ball_load),
    .load_col        (load_col),
    .load_row        (load_row),
    .serve_dir       (serve_dir),
    .score_l         (score_l),
    .score_r         (score_r),
    .game_over       (game_over),
    .winner          (winner),
    .state_o         (state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Game model: phase counts clocks since reset modulo the tick period,
  // srv counts unpaused ticks spent waiting at the serve.
  int m_st = 0, m_sl = 0, m_sr = 0, m_dir = 2, m_go = 0, m_win = 0;
  int m_mt = 0, m_load = 0, m_phase = 0, m_srv = 0, m_sq = 0, m_scorer_r = 0;

  task automatic model_step();
    int tk, rise, col;
    col  = int'(ball_center_col);
    rise = (start && !m_sq) ? 1 : 0;
    m_sq = start ? 1 : 0;
    if (!rst_n) begin
      m_st = 0; m_sl = 0; m_sr = 0; m_dir = 2; m_go = 0; m_win = 0;
      m_mt = 0; m_load = 0; m_phase = 0; m_srv = 0; m_scorer_r = 0;
      return;
    end
    tk      = (m_phase == TD - 1) ? 1 : 0;
    m_phase = (m_phase + 1) % TD;
    m_load  = 0;
    m_mt    = 0;
    if (m_st == 0) begin
      if (rise) begin m_sl = 0; m_sr = 0; m_srv = 0; m_load = 1; m_st = 1; end
    end else if (m_st == 1) begin
      if (tk && !pause) begin
        m_srv++;
        if (m_srv == SD) m_st = 2;
      end
    end else if (m_st == 2) begin
      m_mt = (tk && !pause) ? 1 : 0;
      if (col <= LG) begin
        m_sr++; m_scorer_r = 1; m_dir = 0; m_st = 3;
      end else if (col >= RG) begin
        m_sl++; m_scorer_r = 0; m_dir = 2; m_st = 3;
      end
    end else if (m_st == 3) begin
      if ((m_scorer_r ? m_sr : m_sl) == WS) begin
        m_go = 1; m_win = m_scorer_r; m_st = 4;
      end else begin
        m_srv = 0; m_load = 1; m_st = 1;
      end
    end else begin
      if (rise) begin
        m_sl = 0; m_sr = 0; m_go = 0; m_dir = 2; m_srv = 0; m_load = 1; m_st = 1;
      end
    end
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    check("state",     32'(state_o),   32'(m_st));
    check("score_l",   32'(score_l),   32'(m_sl));
    check("score_r",   32'(score_r),   32'(m_sr));
    check("move_tick", 32'(move_tick), 32'(m_mt));
    check("ball_load", 32'(ball_load), 32'(m_load));
    check("serve_dir", 32'(serve_dir), 32'(m_dir));
    check("game_over", 32'(game_over), 32'(m_go));
    check("load_col",  32'(load_col),  32'(COLS / 2));
    check("load_row",  32'(load_row),  32'(ROWS / 2));
    check("exclusive", 32'(ball_load & move_tick), 32'd0);
    if (m_go != 0) check("winner", 32'(winner), 32'(m_win));
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_state(input logic [2:0] s);
    for (int i = 0; i < 200 && state_o !== s; i++) @(negedge clk);
    check("wait_state", 32'(state_o), 32'(s));
  endtask

  task automatic miss(input logic [11:0] col);
    wait_state(PLAY);
    ball_center_col = col;
    cyc(1);
    ball_center_col = 12'd400;
  endtask

  initial begin
    int gap;
    // Reset with start held high.
    rst_n = 1'b0; start = 1'b1;
    cyc(3);
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_scores", 32'({score_l, score_r}), 32'd0);
    check("rst_dir", 32'(serve_dir), 32'd2);
    check("rst_mt_load", 32'({move_tick, ball_load}), 32'd0);
    rst_n = 1'b1;
    cyc(5);
    check("held_start_idle", 32'(state_o), 32'd0);
    $display("txn reset: state=%0d dir=%0d", state_o, serve_dir);

    // Fresh rising edge starts the game.
    start = 1'b0; cyc(1); start = 1'b1; cyc(1);
    check("start_state", 32'(state_o), 32'd1);
    check("start_load", 32'(ball_load), 32'd1);
    check("load_col_lit", 32'(load_col), 32'd400);
    check("load_row_lit", 32'(load_row), 32'd300);
    start = 1'b0; cyc(1);
    check("load_pulse_end", 32'(ball_load), 32'd0);
    wait_state(PLAY);
    for (int i = 0; i < 20 && move_tick !== 1'b1; i++) @(negedge clk);
    check("first_move_tick", 32'(move_tick), 32'd1);
    gap = 0;
    do begin cyc(1); gap++; end while (move_tick !== 1'b1 && gap < 20);
    check("move_tick_period", 32'(gap), 32'd4);
    $display("txn serve: play reached, move_tick period=%0d", gap);

    // Left miss.
    miss(12'd3);
    check("missl_state", 32'(state_o), 32'd3);
    check("missl_score_r", 32'(score_r), 32'd1);
    check("missl_dir", 32'(serve_dir), 32'd0);
    cyc(1);
    check("missl_serve", 32'(state_o), 32'd1);
    check("missl_load", 32'(ball_load), 32'd1);
    $display("txn miss_left: score_l=%0d score_r=%0d", score_l, score_r);

    // Pause freezes the serve countdown, then pause during play.
    pause = 1'b1; cyc(40);
    check("pause_serve_hold", 32'(state_o), 32'd1);
    pause = 1'b0;
    wait_state(PLAY);
    pause = 1'b1; cyc(12);
    check("pause_play_hold", 32'(state_o), 32'd2);
    ball_center_col = 12'd2; cyc(1); ball_center_col = 12'd400;
    check("pause_miss_state", 32'(state_o), 32'd3);
    check("pause_miss_score", 32'(score_r), 32'd2);
    pause = 1'b0;
    $display("txn pause: score_r=%0d", score_r);

    // Left player wins with right-side misses.
    for (int k = 0; k < WS; k++) miss(12'd797);
    cyc(1);
    check("win_state", 32'(state_o), 32'd4);
    check("win_score_l", 32'(score_l), 32'(WS));
    check("win_game_over", 32'(game_over), 32'd1);
    check("win_winner", 32'(winner), 32'd0);
    start = 1'b1; cyc(1);
    check("restart_state", 32'(state_o), 32'd1);
    check("restart_scores", 32'({score_l, score_r}), 32'd0);
    check("restart_load", 32'(ball_load), 32'd1);
    start = 1'b0;
    $display("txn win: winner=left restarted");

    // Reset in the middle of play.
    for (int k = 0; k < 3; k++) miss(12'd797);
    wait_state(PLAY);
    check("pre_rst_score_l", 32'(score_l), 32'd3);
    rst_n = 1'b0; cyc(1);
    check("midrst_state", 32'(state_o), 32'd0);
    check("midrst_scores", 32'({score_l, score_r}), 32'd0);
    check("midrst_mt", 32'(move_tick), 32'd0);
    rst_n = 1'b1;
    $display("txn mid_reset: state=%0d", state_o);

    // Random play checked cycle by cycle against the model.
    for (int i = 0; i < 4000; i++) begin
      start = ($urandom_range(0, 15) == 0);
      pause = ($urandom_range(0, 7) == 0);
      rst_n = ($urandom_range(0, 999) != 0);
      if ($urandom_range(0, 39) == 0)
        ball_center_col = ($urandom_range(0, 1) == 0) ? 12'($urandom_range(0, LG))
                                                       : 12'($urandom_range(RG, 4095));
      else
        ball_center_col = 12'($urandom_range(LG + 1, RG - 1));
      cyc(1);
    end
    $display("txn random: 4000 cycles");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
